// File: rtl/cory_s2p_flex_if.sv
// Valid/ready bundle for cory_s2p_flex: beat input side, word output side and runtime ratio.
// The slave modport is the converter's view; the master modport is the producer/consumer view.
interface cory_s2p_flex_if #(
    parameter int N = 4,
    parameter int R = 16
);
    localparam int W = N * R;
    localparam int S = $clog2(R + 1);

    logic [S-1:0] i_ratio;
    logic         i_a_v;
    logic [N-1:0] i_a_d;
    logic         i_a_l;
    logic         o_a_r;
    logic         o_z_v;
    logic [W-1:0] o_z_d;
    logic [S-1:0] o_z_s;
    logic         o_z_l;
    logic         i_z_r;

    modport slave (
        input  i_ratio, i_a_v, i_a_d, i_a_l, i_z_r,
        output o_a_r, o_z_v, o_z_d, o_z_s, o_z_l
    );

    modport master (
        output i_ratio, i_a_v, i_a_d, i_a_l, i_z_r,
        input  o_a_r, o_z_v, o_z_d, o_z_s, o_z_l
    );
endinterface

// File: rtl/cory_s2p_flex.sv
// Serial-to-parallel packer: N-bit beats into words of up to R beats, runtime ratio, early close on last.
// Optional CORY_S2P_FLEX_ZERO_PAD_EN clears the accumulator on every close so short words are zero-padded.
module cory_s2p_flex #(
    parameter int N = 4,
    parameter int R = 16,
    parameter int E = 0
) (
    input  logic              clk,
    input  logic              reset,
    cory_s2p_flex_if.slave    bus
);
    localparam int W = N * R;
    localparam int S = $clog2(R + 1);

    logic [S-1:0] cnt_q,   cnt_d;
    logic [S-1:0] ratio_q, ratio_d;
    logic [W-1:0] acc_q,   acc_d;
    logic         z_v_q,   z_v_d;
    logic [W-1:0] z_d_q,   z_d_d;
    logic [S-1:0] z_s_q,   z_s_d;
    logic         z_l_q,   z_l_d;

    logic         a_r;
    logic         accept;
    logic         close;
    logic [S-1:0] eff_ratio;
    logic [S-1:0] cur_ratio;
    logic [S-1:0] slot;
    logic [W-1:0] acc_ins;

    // Input ready depends only on the output register and downstream ready.
    assign a_r       = !z_v_q || bus.i_z_r;
    assign bus.o_a_r = a_r;
    assign bus.o_z_v = z_v_q;
    assign bus.o_z_d = z_d_q;
    assign bus.o_z_s = z_s_q;
    assign bus.o_z_l = z_l_q;

    always_comb begin
        eff_ratio = (bus.i_ratio == '0 || bus.i_ratio > S'(R)) ? S'(R) : bus.i_ratio;
        cur_ratio = (cnt_q == '0) ? eff_ratio : ratio_q;
        slot      = (E != 0) ? (S'(R - 1) - cnt_q) : cnt_q;
        accept    = bus.i_a_v && a_r;
        close     = accept && ((cnt_q == cur_ratio - S'(1)) || bus.i_a_l);

        acc_ins = acc_q;
        for (int i = 0; i < R; i++) begin
            if (slot == S'(i)) begin
                acc_ins[i*N +: N] = bus.i_a_d;
            end
        end

        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        acc_d   = acc_q;
        z_v_d   = z_v_q;
        z_d_d   = z_d_q;
        z_s_d   = z_s_q;
        z_l_d   = z_l_q;

        // A pop empties the output unless a closing beat refills it on the same edge.
        if (bus.i_z_r) begin
            z_v_d = 1'b0;
        end

        if (accept) begin
            if (cnt_q == '0) begin
                ratio_d = eff_ratio;
            end
            if (close) begin
                z_v_d = 1'b1;
                z_d_d = acc_ins;
                z_s_d = cnt_q + S'(1);
                z_l_d = bus.i_a_l;
                cnt_d = '0;
`ifdef CORY_S2P_FLEX_ZERO_PAD_EN
                acc_d = '0;
`else
                acc_d = acc_ins;
`endif
            end else begin
                cnt_d = cnt_q + S'(1);
                acc_d = acc_ins;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            ratio_q <= '0;
            acc_q   <= '0;
            z_v_q   <= 1'b0;
            z_d_q   <= '0;
            z_s_q   <= '0;
            z_l_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            acc_q   <= acc_d;
            z_v_q   <= z_v_d;
            z_d_q   <= z_d_d;
            z_s_q   <= z_s_d;
            z_l_q   <= z_l_d;
        end
    end
endmodule

// File: tb/tb_cory_s2p_flex.sv
// Directed bench for cory_s2p_flex: an E=0 and an E=1 instance share one stimulus stream.
// Expected words are hand-packed constants; CORY_S2P_FLEX_ZERO_PAD_EN selects the short-word expectation.
module tb_cory_s2p_flex;
    localparam int N = 4;
    localparam int R = 16;
    localparam int S = 5;

    typedef struct packed {
        logic [63:0]  d;
        logic [S-1:0] s;
        logic         l;
    } word_t;

    logic  clk;
    logic  reset;
    int    pass_cnt  = 0;
    int    check_cnt = 0;
    int    fail_cnt  = 0;
    word_t words[$];

    cory_s2p_flex_if #(.N(N), .R(R)) bus0 ();
    cory_s2p_flex_if #(.N(N), .R(R)) bus1 ();

    cory_s2p_flex #(.N(N), .R(R), .E(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    cory_s2p_flex #(.N(N), .R(R), .E(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    assign bus1.i_ratio = bus0.i_ratio;
    assign bus1.i_a_v   = bus0.i_a_v;
    assign bus1.i_a_d   = bus0.i_a_d;
    assign bus1.i_a_l   = bus0.i_a_l;
    assign bus1.i_z_r   = bus0.i_z_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Words are logged half a cycle before the edge on which they are popped.
    always @(negedge clk) begin
        if (!reset && bus0.o_z_v && bus0.i_z_r) begin
            words.push_back({bus0.o_z_d, bus0.o_z_s, bus0.o_z_l});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] d, input logic l, output int waits);
        logic accepted;
        accepted      = 1'b0;
        waits         = 0;
        bus0.i_a_v    = 1'b1;
        bus0.i_a_d    = d;
        bus0.i_a_l    = l;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (bus0.o_a_r) accepted = 1'b1;
            else waits++;
            @(posedge clk);
            #1;
        end
        checkOutput("beat_accepted", 64'(accepted), 64'd1);
    endtask

    task automatic idle(input int n);
        bus0.i_a_v = 1'b0;
        bus0.i_a_l = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  t1_beats [16];
        logic [15:0] t2_exp [3];
        logic [7:0]  t4_exp [3];
        int          w;
        int          bubbles;
        int          unstable;

        t1_beats = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                     4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        t2_exp   = '{16'h4321, 16'h8765, 16'hCBA9};
        t4_exp   = '{8'h21, 8'h43, 8'h65};

        reset        = 1'b1;
        bus0.i_ratio = '0;
        bus0.i_a_v   = 1'b0;
        bus0.i_a_d   = '0;
        bus0.i_a_l   = 1'b0;
        bus0.i_z_r   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_z_v", 64'(bus0.o_z_v), 64'd0);
        checkOutput("rst_z_d", bus0.o_z_d, 64'd0);
        checkOutput("rst_z_s", 64'(bus0.o_z_s), 64'd0);
        checkOutput("rst_z_l", 64'(bus0.o_z_l), 64'd0);
        checkOutput("rst_a_r", 64'(bus0.o_a_r), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] T1 ratio 0 full word");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(t1_beats[i], 1'b0, w);
            if (i == 14) checkOutput("t1_no_early_valid", 64'(bus0.o_z_v), 64'd0);
        end
        checkOutput("t1_z_v", 64'(bus0.o_z_v), 64'd1);
        checkOutput("t1_z_d", bus0.o_z_d, 64'hFEDCBA9887654321);
        checkOutput("t1_z_s", 64'(bus0.o_z_s), 64'd16);
        checkOutput("t1_z_l", 64'(bus0.o_z_l), 64'd0);
        idle(1);
        checkOutput("t1_pop_z_v", 64'(bus0.o_z_v), 64'd0);
        checkOutput("t1_pop_z_d_hold", bus0.o_z_d, 64'hFEDCBA9887654321);

        $display("[TB] T2 ratio 4 streaming");
        words.delete();
        bus0.i_ratio = 5'd4;
        bubbles = 0;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(4'(i), 1'b0, w);
            bubbles += w;
        end
        idle(3);
        checkOutput("t2_bubbles", 64'(bubbles), 64'd0);
        checkOutput("t2_word_count", 64'(words.size()), 64'd3);
        for (int i = 0; i < 3 && i < words.size(); i++) begin
            checkOutput("t2_word_d", 64'(words[i].d[15:0]), 64'(t2_exp[i]));
            checkOutput("t2_word_s", 64'(words[i].s), 64'd4);
            checkOutput("t2_word_l", 64'(words[i].l), 64'd0);
        end

        $display("[TB] T2b ratio latched per word, last closes early");
        bus0.i_ratio = 5'd3;
        applyStimulus(4'h1, 1'b0, w);
        bus0.i_ratio = 5'd0;
        applyStimulus(4'h2, 1'b0, w);
        applyStimulus(4'h3, 1'b0, w);
        checkOutput("t2b_z_v", 64'(bus0.o_z_v), 64'd1);
        checkOutput("t2b_z_s", 64'(bus0.o_z_s), 64'd3);
        checkOutput("t2b_z_d", 64'(bus0.o_z_d[11:0]), 64'h321);
        applyStimulus(4'h4, 1'b0, w);
        checkOutput("t2b_second_pending", 64'(bus0.o_z_v), 64'd0);
        applyStimulus(4'h5, 1'b1, w);
        checkOutput("t2b_last_z_s", 64'(bus0.o_z_s), 64'd2);
        checkOutput("t2b_last_z_l", 64'(bus0.o_z_l), 64'd1);
        checkOutput("t2b_last_z_d", 64'(bus0.o_z_d[7:0]), 64'h54);
        idle(2);

        $display("[TB] T3 short word via last");
        bus0.i_ratio = 5'd16;
        applyStimulus(4'hA, 1'b0, w);
        applyStimulus(4'hB, 1'b0, w);
        applyStimulus(4'hC, 1'b1, w);
        checkOutput("t3_z_v", 64'(bus0.o_z_v), 64'd1);
        checkOutput("t3_z_s", 64'(bus0.o_z_s), 64'd3);
        checkOutput("t3_z_l", 64'(bus0.o_z_l), 64'd1);
`ifdef CORY_S2P_FLEX_ZERO_PAD_EN
        checkOutput("t3_z_d_padded", bus0.o_z_d, 64'hCBA);
`else
        checkOutput("t3_z_d_low", 64'(bus0.o_z_d[11:0]), 64'hCBA);
`endif
        idle(1);
        applyStimulus(4'h7, 1'b1, w);
        checkOutput("t3_single_z_s", 64'(bus0.o_z_s), 64'd1);
        checkOutput("t3_single_z_l", 64'(bus0.o_z_l), 64'd1);
        checkOutput("t3_single_z_d", 64'(bus0.o_z_d[3:0]), 64'h7);

        $display("[TB] T3b ratio 1");
        bus0.i_ratio = 5'd1;
        applyStimulus(4'h5, 1'b0, w);
        checkOutput("t3b_first_z_s", 64'(bus0.o_z_s), 64'd1);
        checkOutput("t3b_first_z_d", 64'(bus0.o_z_d[3:0]), 64'h5);
        checkOutput("t3b_first_z_l", 64'(bus0.o_z_l), 64'd0);
        applyStimulus(4'h6, 1'b0, w);
        checkOutput("t3b_second_z_v", 64'(bus0.o_z_v), 64'd1);
        checkOutput("t3b_second_z_d", 64'(bus0.o_z_d[3:0]), 64'h6);
        idle(2);

        $display("[TB] T4 backpressure ratio 2");
        words.delete();
        bus0.i_ratio = 5'd2;
        applyStimulus(4'h1, 1'b0, w);
        applyStimulus(4'h2, 1'b0, w);
        bus0.i_z_r = 1'b0;
        bus0.i_a_v = 1'b1;
        bus0.i_a_d = 4'h3;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus0.o_a_r !== 1'b0 || bus0.o_z_v !== 1'b1 || bus0.o_z_d[7:0] !== 8'h21
                || bus0.o_z_s !== 5'd2) unstable++;
        end
        checkOutput("t4_stall_stable", 64'(unstable), 64'd0);
        @(posedge clk);
        #1;
        bus0.i_z_r = 1'b1;
        for (int i = 3; i <= 6; i++) applyStimulus(4'(i), 1'b0, w);
        idle(3);
        checkOutput("t4_word_count", 64'(words.size()), 64'd3);
        for (int i = 0; i < 3 && i < words.size(); i++) begin
            checkOutput("t4_word_d", 64'(words[i].d[7:0]), 64'(t4_exp[i]));
            checkOutput("t4_word_s", 64'(words[i].s), 64'd2);
        end

        $display("[TB] T5 beat order E=1");
        bus0.i_ratio = 5'd0;
        for (int i = 1; i <= 16; i++) applyStimulus(4'(i), 1'b0, w);
        checkOutput("t5_e1_z_d", bus1.o_z_d, 64'h123456789ABCDEF0);
        checkOutput("t5_e1_z_s", 64'(bus1.o_z_s), 64'd16);
        checkOutput("t5_e0_z_d", bus0.o_z_d, 64'h0FEDCBA987654321);
        idle(2);

        $display("[TB] T6 reset mid-stall and mid-word");
        bus0.i_ratio = 5'd1;
        bus0.i_z_r   = 1'b0;
        applyStimulus(4'h9, 1'b0, w);
        bus0.i_a_v = 1'b0;
        checkOutput("t6_stalled_z_v", 64'(bus0.o_z_v), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_async_drop_z_v", 64'(bus0.o_z_v), 64'd0);
        @(negedge clk);
        reset      = 1'b0;
        bus0.i_z_r = 1'b1;
        @(posedge clk);
        #1;
        bus0.i_ratio = 5'd0;
        for (int i = 0; i < 5; i++) applyStimulus(4'hE, 1'b0, w);
        bus0.i_a_v = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6_rst_z_v", 64'(bus0.o_z_v), 64'd0);
        checkOutput("t6_rst_z_d", bus0.o_z_d, 64'd0);
        checkOutput("t6_rst_z_s", 64'(bus0.o_z_s), 64'd0);
        checkOutput("t6_rst_z_l", 64'(bus0.o_z_l), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        words.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) applyStimulus(4'(i), 1'b0, w);
        idle(3);
        checkOutput("t6_word_count", 64'(words.size()), 64'd1);
        if (words.size() > 0) begin
            checkOutput("t6_word_d", words[0].d, 64'hFEDCBA9876543210);
            checkOutput("t6_word_s", 64'(words[0].s), 64'd16);
            checkOutput("t6_word_l", 64'(words[0].l), 64'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
